// File: rtl/conv_pkg.sv
// FP32 field constants, operand struct, FSM state encoding and helpers for the conv MAC cell.
// Pure declarations; no latency or backpressure of its own.
package conv_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } conv_state_e;

  function automatic fp32_t fp_inf(input logic s);
    fp_inf = fp32_t'({s, 8'hFF, 23'd0});
  endfunction

  function automatic fp32_t fp_zero(input logic s);
    fp_zero = fp32_t'({s, 31'd0});
  endfunction

  // Leading-zero count over the 27-bit adder datapath (24 mantissa + 3 guard bits).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational FP32 multiply, truncating, denormals flushed, overflow saturates to infinity.
// Zero latency; no handshake, the caller registers the result.
module fp32_mul
  import conv_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t p,
  output logic  ovf
);

  logic               sgn;
  logic [47:0]        mprod;
  logic signed [9:0]  e_sum;
  logic [23:0]        mant;

  always_comb begin
    sgn   = a.sign ^ b.sign;
    mprod = {1'b1, a.man} * {1'b1, b.man};
    mant  = mprod[47] ? mprod[47:24] : mprod[46:23];
    e_sum = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127
            + (mprod[47] ? 10'sd1 : 10'sd0);
    p   = '0;
    ovf = 1'b0;
    // Infinity dominates, so inf*0 is still infinity rather than NaN.
    if (a.exp == 8'hFF || b.exp == 8'hFF) begin
      p   = fp_inf(sgn);
      ovf = 1'b1;
    end else if (a.exp == 8'h00 || b.exp == 8'h00) begin
      p = fp_zero(sgn);
    end else if (e_sum < 10'sd1) begin
      p = fp_zero(sgn);
    end else if (e_sum >= 10'sd255) begin
      p   = fp_inf(sgn);
      ovf = 1'b1;
    end else begin
      p = fp32_t'({sgn, e_sum[7:0], mant[22:0]});
    end
  end

endmodule

// File: rtl/conv_mac_fp32.sv
// FP32 multiply-accumulate over KSIZE*KSIZE pairs; 3 cycles per pair, c_valid 3 cycles after last accept.
// a_ready only in WAIT; optional CONV_MAC_RELU_EN clamps negative results to +0.
module conv_mac_fp32
  import conv_pkg::*;
#(
  parameter int KSIZE = 3,
  parameter int CNT_W = $clog2(KSIZE*KSIZE+1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C,
  output logic        c_valid,
  output logic        busy,
  output logic        ovf
);

  localparam logic [CNT_W-1:0] KK = CNT_W'(KSIZE*KSIZE);

  conv_state_e       state;
  fp32_t             a_q, b_q, prod_q, acc;
  fp32_t             mul_p, add_res, x, y, c_nxt;
  logic              mul_ovf, add_ovf;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  fp32_mul u_mul (
    .a   (a_q),
    .b   (b_q),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  // Adder: operands ordered by magnitude so the aligned difference is never negative.
  logic [30:0]       mag_acc, mag_prod;
  logic              swap, y_zero;
  logic [7:0]        d;
  logic [26:0]       mx, my, my_sh, diff, norm;
  logic [27:0]       sum28;
  logic [4:0]        lz;
  logic signed [9:0] e_res;
  logic [23:0]       mant;
  logic              rsgn, pack;

  always_comb begin
    mag_acc  = (acc.exp == 8'h00)    ? 31'd0 : acc[30:0];
    mag_prod = (prod_q.exp == 8'h00) ? 31'd0 : prod_q[30:0];
    swap     = mag_prod > mag_acc;
    x        = swap ? prod_q : acc;
    y        = swap ? acc : prod_q;
    y_zero   = (swap ? mag_acc : mag_prod) == 31'd0;
    mx       = {1'b1, x.man, 3'b000};
    my       = y_zero ? 27'd0 : {1'b1, y.man, 3'b000};
    d        = x.exp - y.exp;
    my_sh    = (d >= 8'd27) ? 27'd0 : (my >> d[4:0]);
    sum28    = {1'b0, mx} + {1'b0, my_sh};
    diff     = mx - my_sh;
    lz       = lzc27(diff);
    norm     = diff << lz;

    add_res = '0;
    add_ovf = 1'b0;
    e_res   = '0;
    mant    = '0;
    rsgn    = x.sign;
    pack    = 1'b0;
    if (acc.exp == 8'hFF || prod_q.exp == 8'hFF) begin
      // Opposite-signed infinities resolve to +inf.
      if (acc.exp == 8'hFF && prod_q.exp == 8'hFF) rsgn = acc.sign & prod_q.sign;
      else if (acc.exp == 8'hFF)                   rsgn = acc.sign;
      else                                         rsgn = prod_q.sign;
      add_res = fp_inf(rsgn);
      add_ovf = 1'b1;
    end else if ((swap ? mag_prod : mag_acc) == 31'd0) begin
      add_res = '0;
    end else if (x.sign == y.sign) begin
      e_res = $signed({2'b00, x.exp}) + $signed({9'd0, sum28[27]});
      mant  = sum28[27] ? sum28[27:4] : sum28[26:3];
      pack  = 1'b1;
    end else if (diff == 27'd0) begin
      add_res = '0;
    end else begin
      e_res = $signed({2'b00, x.exp}) - $signed({5'd0, lz});
      mant  = norm[26:3];
      pack  = 1'b1;
    end

    if (pack) begin
      if (e_res < 10'sd1) begin
        add_res = fp_zero(rsgn);
      end else if (e_res >= 10'sd255) begin
        add_res = fp_inf(rsgn);
        add_ovf = 1'b1;
      end else begin
        add_res = fp32_t'({rsgn, e_res[7:0], mant[22:0]});
      end
    end
  end

`ifdef CONV_MAC_RELU_EN
  assign c_nxt = add_res.sign ? fp32_t'(32'd0) : add_res;
`else
  assign c_nxt = add_res;
`endif

  assign cnt_nxt = cnt + 1'b1;
  assign a_ready = (state == ST_WAIT);
  assign busy    = (state != ST_IDLE);
  assign c_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      C      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (a_valid) begin
            a_q   <= A;
            b_q   <= B;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          prod_q <= mul_p;
          if (mul_ovf) ovf <= 1'b1;
          state  <= ST_ADD;
        end
        ST_ADD: begin
          acc <= add_res;
          cnt <= cnt_nxt;
          if (add_ovf) ovf <= 1'b1;
          // C is loaded here so it is already final during the c_valid cycle.
          if (cnt_nxt == KK) begin
            C     <= c_nxt;
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
